// File: rtl/vram_sched.sv
// -----------------------------------------------------------------------------
// vram_sched
//   Single-word VRAM access scheduler. The video generator always wins a
//   slot when it asks. Otherwise the non-video requesters (0 = regs,
//   1 = blit, 2 = draw) share the remaining slots round-robin. All outputs
//   are registered. A granted requester sees a one-cycle ack pulse in the
//   same cycle that its command is on the vram_* outputs.
//
// Ports
//   clk            system clock
//   reset_i        asynchronous, active-high reset
//   vgen_sel_i     video generator read request for this cycle (never acked)
//   vgen_addr_i    video generator read address
//   req_sel_i      per-requester access request
//   req_wr_i       per-requester write (1) / read (0)
//   req_wr_mask_i  per-requester nibble write mask, slice [4k+3:4k]
//   req_addr_i     per-requester word address, slice k
//   req_data_i     per-requester write data, slice k
//   req_ack_o      one-cycle accept pulse per requester
//   vram_sel_o     VRAM access strobe
//   vram_wr_o      VRAM write enable
//   vram_wr_mask_o VRAM nibble write mask
//   vram_addr_o    VRAM word address
//   vram_data_o    VRAM write data
//   grant_id_o     slot owner: 0..NREQ-1 = requester, 3 = vgen or idle
// -----------------------------------------------------------------------------
module vram_sched #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     reset_i,
    input  logic                     vgen_sel_i,
    input  logic [ADDR_W-1:0]        vgen_addr_i,
    input  logic [NREQ-1:0]          req_sel_i,
    input  logic [NREQ-1:0]          req_wr_i,
    input  logic [NREQ*4-1:0]        req_wr_mask_i,
    input  logic [NREQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NREQ*DATA_W-1:0]   req_data_i,
    output logic [NREQ-1:0]          req_ack_o,
    output logic                     vram_sel_o,
    output logic                     vram_wr_o,
    output logic [3:0]               vram_wr_mask_o,
    output logic [ADDR_W-1:0]        vram_addr_o,
    output logic [DATA_W-1:0]        vram_data_o,
    output logic [1:0]               grant_id_o
);

    localparam logic [1:0] GID_IDLE = 2'd3;
    localparam logic [1:0] PTR_INIT = 2'(NREQ - 1);

    logic [NREQ-1:0]   req_ack_r;
    logic              vram_sel_r;
    logic              vram_wr_r;
    logic [3:0]        vram_wr_mask_r;
    logic [ADDR_W-1:0] vram_addr_r;
    logic [DATA_W-1:0] vram_data_r;
    logic [1:0]        grant_id_r;
    logic [1:0]        rr_ptr_r;

    logic [NREQ-1:0]   eligible_s;
    logic [1:0]        cand_s;
    logic              win_found_s;
    logic [1:0]        win_idx_s;
    logic              win_wr_s;
    logic [3:0]        win_mask_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_data_s;
    logic [NREQ-1:0]   win_ack_s;

    // A requester still seeing its ack this cycle has not yet dropped sel,
    // so it must not be granted again.
    assign eligible_s = req_sel_i & ~req_ack_r;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = 2'd0;
        cand_s      = 2'd0;
        for (int i = 1; i <= NREQ; i++) begin
            cand_s = 2'((int'(rr_ptr_r) + i) % NREQ);
            if (!win_found_s && eligible_s[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    assign win_wr_s   = req_wr_i[win_idx_s];
    assign win_mask_s = req_wr_mask_i[4*win_idx_s +: 4];
    assign win_addr_s = req_addr_i[ADDR_W*win_idx_s +: ADDR_W];
    assign win_data_s = req_data_i[DATA_W*win_idx_s +: DATA_W];
    assign win_ack_s  = {{(NREQ-1){1'b0}}, 1'b1} << win_idx_s;

    // Command, ack and round-robin pointer registers.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            req_ack_r      <= '0;
            vram_sel_r     <= 1'b0;
            vram_wr_r      <= 1'b0;
            vram_wr_mask_r <= 4'h0;
            vram_addr_r    <= '0;
            vram_data_r    <= '0;
            grant_id_r     <= GID_IDLE;
            rr_ptr_r       <= PTR_INIT;
        end else if (vgen_sel_i) begin
            // Video slot: plain read, pointer untouched, write data held.
            req_ack_r      <= '0;
            vram_sel_r     <= 1'b1;
            vram_wr_r      <= 1'b0;
            vram_wr_mask_r <= 4'h0;
            vram_addr_r    <= vgen_addr_i;
            grant_id_r     <= GID_IDLE;
        end else if (win_found_s) begin
            // An all-zero write mask degrades to a harmless read.
            req_ack_r      <= win_ack_s;
            vram_sel_r     <= 1'b1;
            vram_wr_r      <= win_wr_s & (|win_mask_s);
            vram_wr_mask_r <= win_wr_s ? win_mask_s : 4'h0;
            vram_addr_r    <= win_addr_s;
            vram_data_r    <= win_data_s;
            grant_id_r     <= win_idx_s;
            rr_ptr_r       <= win_idx_s;
        end else begin
            // Idle slot: mask/addr/data keep their previous values.
            req_ack_r      <= '0;
            vram_sel_r     <= 1'b0;
            vram_wr_r      <= 1'b0;
            grant_id_r     <= GID_IDLE;
        end
    end

    assign req_ack_o      = req_ack_r;
    assign vram_sel_o     = vram_sel_r;
    assign vram_wr_o      = vram_wr_r;
    assign vram_wr_mask_o = vram_wr_mask_r;
    assign vram_addr_o    = vram_addr_r;
    assign vram_data_o    = vram_data_r;
    assign grant_id_o     = grant_id_r;

endmodule

// File: tb/tb_vram_sched.sv
// -----------------------------------------------------------------------------
// tb_vram_sched
//   Directed, self-checking bench for vram_sched: a table of single-cycle
//   vectors with hand-computed expectations, followed by hand-written
//   multi-cycle sequences (vgen priority, round-robin, async reset, re-request).
// -----------------------------------------------------------------------------
module tb_vram_sched;

    logic        clk;
    logic        reset_i;
    logic        vgen_sel_i;
    logic [15:0] vgen_addr_i;
    logic [2:0]  req_sel_i;
    logic [2:0]  req_wr_i;
    logic [11:0] req_wr_mask_i;
    logic [47:0] req_addr_i;
    logic [47:0] req_data_i;
    logic [2:0]  req_ack_o;
    logic        vram_sel_o;
    logic        vram_wr_o;
    logic [3:0]  vram_wr_mask_o;
    logic [15:0] vram_addr_o;
    logic [15:0] vram_data_o;
    logic [1:0]  grant_id_o;

    int checks;
    int errors;

    vram_sched #(.NREQ(3), .ADDR_W(16), .DATA_W(16)) dut (
        .clk            (clk),
        .reset_i        (reset_i),
        .vgen_sel_i     (vgen_sel_i),
        .vgen_addr_i    (vgen_addr_i),
        .req_sel_i      (req_sel_i),
        .req_wr_i       (req_wr_i),
        .req_wr_mask_i  (req_wr_mask_i),
        .req_addr_i     (req_addr_i),
        .req_data_i     (req_data_i),
        .req_ack_o      (req_ack_o),
        .vram_sel_o     (vram_sel_o),
        .vram_wr_o      (vram_wr_o),
        .vram_wr_mask_o (vram_wr_mask_o),
        .vram_addr_o    (vram_addr_o),
        .vram_data_o    (vram_data_o),
        .grant_id_o     (grant_id_o)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vs;
        logic [15:0] va;
        logic [2:0]  rs;
        logic [2:0]  rw;
        logic [11:0] rm;
        logic        e_sel;
        logic        e_wr;
        logic [3:0]  e_mask;
        logic [15:0] e_addr;
        logic [15:0] e_data;
        logic [2:0]  e_ack;
        logic [1:0]  e_gid;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic vs, input logic [15:0] va,
                                input logic [2:0] rs, input logic [2:0] rw,
                                input logic [11:0] rm, input logic es,
                                input logic ew, input logic [3:0] em,
                                input logic [15:0] ea, input logic [15:0] ed,
                                input logic [2:0] eack, input logic [1:0] egid);
        vec_t v;
        v.vs = vs; v.va = va; v.rs = rs; v.rw = rw; v.rm = rm;
        v.e_sel = es; v.e_wr = ew; v.e_mask = em; v.e_addr = ea;
        v.e_data = ed; v.e_ack = eack; v.e_gid = egid;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_i       = 1'b1;
        vgen_sel_i    = 1'b0;
        vgen_addr_i   = 16'h0000;
        req_sel_i     = 3'b000;
        req_wr_i      = 3'b000;
        req_wr_mask_i = 12'h000;
        // Fixed per-requester addresses and data: r2, r1, r0.
        req_addr_i    = {16'h2000, 16'h0040, 16'h1234};
        req_data_i    = {16'h2222, 16'hBEEF, 16'h1111};

        // Reset state
        #1;
        chk("rst sel",  32'(vram_sel_o),     32'h0);
        chk("rst wr",   32'(vram_wr_o),      32'h0);
        chk("rst mask", 32'(vram_wr_mask_o), 32'h0);
        chk("rst addr", 32'(vram_addr_o),    32'h0);
        chk("rst data", 32'(vram_data_o),    32'h0);
        chk("rst ack",  32'(req_ack_o),      32'h0);
        chk("rst gid",  32'(grant_id_o),     32'h3);
        @(posedge clk);
        #1;
        reset_i = 1'b0;

        // Table: sequential vectors, pointer starts at 2 (req 0 first).
        vecs[0]  = mk(1'b0, 16'h0000, 3'b000, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 3'b000, 2'd3);
        vecs[1]  = mk(1'b0, 16'h0000, 3'b001, 3'b000, 12'h000, 1'b1, 1'b0, 4'h0, 16'h1234, 16'h1111, 3'b001, 2'd0);
        vecs[2]  = mk(1'b0, 16'h0000, 3'b000, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0, 16'h1234, 16'h1111, 3'b000, 2'd3);
        vecs[3]  = mk(1'b0, 16'h0000, 3'b001, 3'b000, 12'h000, 1'b1, 1'b0, 4'h0, 16'h1234, 16'h1111, 3'b001, 2'd0);
        vecs[4]  = mk(1'b0, 16'h0000, 3'b001, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0, 16'h1234, 16'h1111, 3'b000, 2'd3);
        vecs[5]  = mk(1'b1, 16'hABCD, 3'b010, 3'b010, 12'h0F0, 1'b1, 1'b0, 4'h0, 16'hABCD, 16'h1111, 3'b000, 2'd3);
        vecs[6]  = mk(1'b0, 16'h0000, 3'b010, 3'b010, 12'h0F0, 1'b1, 1'b1, 4'hF, 16'h0040, 16'hBEEF, 3'b010, 2'd1);
        vecs[7]  = mk(1'b0, 16'h0000, 3'b100, 3'b100, 12'h000, 1'b1, 1'b0, 4'h0, 16'h2000, 16'h2222, 3'b100, 2'd2);
        vecs[8]  = mk(1'b0, 16'h0000, 3'b101, 3'b000, 12'h005, 1'b1, 1'b0, 4'h0, 16'h1234, 16'h1111, 3'b001, 2'd0);
        vecs[9]  = mk(1'b0, 16'h0000, 3'b100, 3'b100, 12'h300, 1'b1, 1'b1, 4'h3, 16'h2000, 16'h2222, 3'b100, 2'd2);
        vecs[10] = mk(1'b0, 16'h0000, 3'b011, 3'b001, 12'h00A, 1'b1, 1'b1, 4'hA, 16'h1234, 16'h1111, 3'b001, 2'd0);
        vecs[11] = mk(1'b0, 16'h0000, 3'b010, 3'b000, 12'h000, 1'b1, 1'b0, 4'h0, 16'h0040, 16'hBEEF, 3'b010, 2'd1);
        vecs[12] = mk(1'b0, 16'h0000, 3'b000, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0, 16'h0040, 16'hBEEF, 3'b000, 2'd3);
        vecs[13] = mk(1'b0, 16'h0000, 3'b001, 3'b001, 12'h00F, 1'b1, 1'b1, 4'hF, 16'h1234, 16'h1111, 3'b001, 2'd0);
        vecs[14] = mk(1'b0, 16'h0000, 3'b000, 3'b000, 12'h000, 1'b0, 1'b0, 4'hF, 16'h1234, 16'h1111, 3'b000, 2'd3);

        for (int i = 0; i < NVEC; i++) begin
            vgen_sel_i    = vecs[i].vs;
            vgen_addr_i   = vecs[i].va;
            req_sel_i     = vecs[i].rs;
            req_wr_i      = vecs[i].rw;
            req_wr_mask_i = vecs[i].rm;
            tick();
            chk($sformatf("v%0d sel", i),  32'(vram_sel_o),     32'(vecs[i].e_sel));
            chk($sformatf("v%0d wr", i),   32'(vram_wr_o),      32'(vecs[i].e_wr));
            chk($sformatf("v%0d mask", i), 32'(vram_wr_mask_o), 32'(vecs[i].e_mask));
            chk($sformatf("v%0d addr", i), 32'(vram_addr_o),    32'(vecs[i].e_addr));
            chk($sformatf("v%0d data", i), 32'(vram_data_o),    32'(vecs[i].e_data));
            chk($sformatf("v%0d ack", i),  32'(req_ack_o),      32'(vecs[i].e_ack));
            chk($sformatf("v%0d gid", i),  32'(grant_id_o),     32'(vecs[i].e_gid));
        end

        // vgen holds the bus for 5 cycles while req1 write waits.
        vgen_sel_i    = 1'b1;
        req_sel_i     = 3'b010;
        req_wr_i      = 3'b010;
        req_wr_mask_i = 12'h0F0;
        for (int i = 0; i < 5; i++) begin
            vgen_addr_i = 16'h8000 + 16'(i);
            tick();
            chk($sformatf("vg%0d sel", i),  32'(vram_sel_o),  32'h1);
            chk($sformatf("vg%0d wr", i),   32'(vram_wr_o),   32'h0);
            chk($sformatf("vg%0d addr", i), 32'(vram_addr_o), 32'h8000 + 32'(i));
            chk($sformatf("vg%0d ack", i),  32'(req_ack_o),   32'h0);
            chk($sformatf("vg%0d gid", i),  32'(grant_id_o),  32'h3);
        end
        vgen_sel_i = 1'b0;
        tick();
        chk("vgdone wr",   32'(vram_wr_o),      32'h1);
        chk("vgdone mask", 32'(vram_wr_mask_o), 32'hF);
        chk("vgdone addr", 32'(vram_addr_o),    32'h0040);
        chk("vgdone data", 32'(vram_data_o),    32'hBEEF);
        chk("vgdone ack",  32'(req_ack_o),      32'h2);
        chk("vgdone gid",  32'(grant_id_o),     32'h1);
        req_sel_i = 3'b000;
        tick();
        chk("vgidle ack", 32'(req_ack_o), 32'h0);

        // All three requesters held: strict 0,1,2 rotation.
        req_wr_i      = 3'b000;
        req_wr_mask_i = 12'h000;
        do_reset();
        req_sel_i = 3'b111;
        for (int c = 0; c < 9; c++) begin
            tick();
            chk($sformatf("rr%0d ack", c), 32'(req_ack_o),  32'h1 << (c % 3));
            chk($sformatf("rr%0d gid", c), 32'(grant_id_o), 32'(c % 3));
            chk($sformatf("rr%0d sel", c), 32'(vram_sel_o), 32'h1);
        end
        req_sel_i = 3'b000;
        tick();

        // Async reset in the middle of a req1 ack cycle.
        do_reset();
        req_sel_i = 3'b010;
        tick();
        chk("ra pre ack", 32'(req_ack_o), 32'h2);
        #2;
        reset_i   = 1'b1;
        req_sel_i = 3'b011;
        #1;
        chk("ra mid ack", 32'(req_ack_o),  32'h0);
        chk("ra mid sel", 32'(vram_sel_o), 32'h0);
        chk("ra mid gid", 32'(grant_id_o), 32'h3);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        tick();
        chk("ra g0 ack", 32'(req_ack_o),  32'h1);
        chk("ra g0 gid", 32'(grant_id_o), 32'h0);
        tick();
        chk("ra g1 ack", 32'(req_ack_o),  32'h2);
        chk("ra g1 gid", 32'(grant_id_o), 32'h1);
        req_sel_i = 3'b000;
        tick();

        // req0 re-requests right after each ack, req1 held: 0,1,0,1.
        do_reset();
        req_sel_i = 3'b011;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("alt%0d ack", c), 32'(req_ack_o),  32'h1 << (c % 2));
            chk($sformatf("alt%0d gid", c), 32'(grant_id_o), 32'(c % 2));
        end
        req_sel_i = 3'b000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
